me_ref_search_mem: RTL and testbench

Memory subsystem feeding the full-search block-matching motion estimator (`top`). It holds the 16×16 reference block (R memory, 256 × 8 bit) and the 31×31 search window (S memory, 1024 × 8 bit, 961 locations used). It serves one registered read port on R and two independent registered read ports on S, which the estimator's processing array addresses every cycle. A single write port loads both memories before a run starts.

---
 rtl/me_pkg.sv | 15 +
 rtl/me_mem_bank.sv | 36 +++
 rtl/me_ref_search_mem.sv | 72 +++++++
 tb/tb_me_ref_search_mem.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/me_pkg.sv
// Shared constants and types for the motion-estimator reference/search memories.
package me_pkg;

    localparam int unsigned RMEM_MAX   = 256;
    localparam int unsigned SMEM_MAX   = 1024;
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned R_ADDR_W   = 8;
    localparam int unsigned S_ADDR_W   = 10;
    localparam int unsigned BLK_SIZE   = 16;
    localparam int unsigned WIN_SIZE   = 31;
    localparam int unsigned ROW_STRIDE = 32;

    typedef logic [7:0] pixel_t;

endpackage

// File: rtl/me_mem_bank.sv
// Depth x width storage array with one write port and NRD registered, read-first read ports.
module me_mem_bank #(
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned NRD    = 1
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         we,
    input  logic [ADDR_W-1:0]            waddr,
    input  logic [WIDTH-1:0]             wdata,
    input  logic [NRD-1:0][ADDR_W-1:0]   raddr,
    output logic [NRD-1:0][WIDTH-1:0]    rdata
);

    logic [WIDTH-1:0] mem [0:DEPTH-1];

    // Contents survive reset; writes are simply suppressed while reset is held.
    always_ff @(posedge clock) begin
        if (we && reset_n) begin
            mem[waddr] <= wdata;
        end
    end

    for (genvar p = 0; p < int'(NRD); p++) begin : g_rd
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                rdata[p] <= '0;
            end else begin
                rdata[p] <= mem[raddr[p]];
            end
        end
    end

endmodule

// File: rtl/me_ref_search_mem.sv
// Reference-block (R) and search-window (S) memories for the full-search estimator.
module me_ref_search_mem
    import me_pkg::*;
#(
    parameter int unsigned RMEM_MAX = me_pkg::RMEM_MAX,
    parameter int unsigned SMEM_MAX = me_pkg::SMEM_MAX,
    parameter int unsigned DATA_W   = me_pkg::DATA_W
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [R_ADDR_W-1:0]  AddressR,
    input  logic [S_ADDR_W-1:0]  AddressS1,
    input  logic [S_ADDR_W-1:0]  AddressS2,
    output logic [DATA_W-1:0]    R,
    output logic [DATA_W-1:0]    S1,
    output logic [DATA_W-1:0]    S2,
    input  logic                 we,
    input  logic                 wsel,
    input  logic [S_ADDR_W-1:0]  waddr,
    input  logic [DATA_W-1:0]    wdata
);

    logic                        r_we_c;
    logic                        s_we_c;
    logic [0:0][DATA_W-1:0]      r_rd;
    logic [1:0][DATA_W-1:0]      s_rd;
    logic [0:0][R_ADDR_W-1:0]    r_ra;
    logic [1:0][S_ADDR_W-1:0]    s_ra;

    // R writes with address bits above the R range set are dropped, not aliased.
    assign r_we_c = we && !wsel && (waddr[S_ADDR_W-1:R_ADDR_W] == '0);
    assign s_we_c = we && wsel;

    assign r_ra[0] = AddressR;
    assign s_ra[0] = AddressS1;
    assign s_ra[1] = AddressS2;

    me_mem_bank #(
        .DEPTH  (RMEM_MAX),
        .WIDTH  (DATA_W),
        .ADDR_W (R_ADDR_W),
        .NRD    (1)
    ) Rmem (
        .clock   (clock),
        .reset_n (reset_n),
        .we      (r_we_c),
        .waddr   (waddr[R_ADDR_W-1:0]),
        .wdata   (wdata),
        .raddr   (r_ra),
        .rdata   (r_rd)
    );

    me_mem_bank #(
        .DEPTH  (SMEM_MAX),
        .WIDTH  (DATA_W),
        .ADDR_W (S_ADDR_W),
        .NRD    (2)
    ) Smem (
        .clock   (clock),
        .reset_n (reset_n),
        .we      (s_we_c),
        .waddr   (waddr),
        .wdata   (wdata),
        .raddr   (s_ra),
        .rdata   (s_rd)
    );

    assign R  = r_rd[0];
    assign S1 = s_rd[0];
    assign S2 = s_rd[1];

endmodule

// File: tb/tb_me_ref_search_mem.sv
// Directed self-checking bench for me_ref_search_mem.
module tb_me_ref_search_mem;

    logic       clock;
    logic       reset_n;
    logic [7:0] AddressR;
    logic [9:0] AddressS1;
    logic [9:0] AddressS2;
    logic [7:0] R;
    logic [7:0] S1;
    logic [7:0] S2;
    logic       we;
    logic       wsel;
    logic [9:0] waddr;
    logic [7:0] wdata;

    int total = 0;
    int bad   = 0;

    me_ref_search_mem dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .AddressR  (AddressR),
        .AddressS1 (AddressS1),
        .AddressS2 (AddressS2),
        .R         (R),
        .S1        (S1),
        .S2        (S2),
        .we        (we),
        .wsel      (wsel),
        .waddr     (waddr),
        .wdata     (wdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic sel, input logic [9:0] a, input logic [7:0] d);
        we = 1'b1; wsel = sel; waddr = a; wdata = d;
        tick();
        we = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; we = 1'b0; wsel = 1'b0; waddr = '0; wdata = '0;
        AddressR = '0; AddressS1 = '0; AddressS2 = '0;
        tick();
        tick();
        check("rst_R", R, 8'h00);
        check("rst_S1", S1, 8'h00);
        check("rst_S2", S2, 8'h00);
        reset_n = 1'b1;
        tick();

        // zero-preload through the write port
        for (int i = 0; i < 256; i++) wr(1'b0, 10'(i), 8'h00);
        for (int i = 0; i < 1024; i++) wr(1'b1, 10'(i), 8'h00);

        // back-to-back sweep, one new address every cycle
        for (int i = 0; i < 256; i++) begin
            AddressR = 8'(i);
            tick();
            check("sweep_R", R, 8'h00);
        end
        for (int i = 0; i < 961; i++) begin
            AddressS1 = 10'(i);
            AddressS2 = 10'(960 - i);
            tick();
            check("sweep_S1", S1, 8'h00);
            check("sweep_S2", S2, 8'h00);
        end

        wr(1'b0, 10'h000, 8'h11);
        wr(1'b0, 10'h0FF, 8'hEE);
        wr(1'b1, 10'd0,   8'h05);
        wr(1'b1, 10'd960, 8'hA5);
        wr(1'b0, 10'h010, 8'h33);
        wr(1'b0, 10'h020, 8'hAA);
        wr(1'b1, 10'd100, 8'hAA);
        wr(1'b1, 10'd200, 8'hBB);

        // R latency and hold
        AddressR = 8'h00;
        tick();
        check("r_00", R, 8'h11);
        AddressR = 8'hFF;
        #2;
        check("r_hold", R, 8'h11);
        tick();
        check("r_ff", R, 8'hEE);

        // dual S ports
        AddressS1 = 10'd0; AddressS2 = 10'd960;
        tick();
        check("s1_0", S1, 8'h05);
        check("s2_960", S2, 8'hA5);
        AddressS1 = 10'd960;
        tick();
        check("s1_same", S1, 8'hA5);
        check("s2_same", S2, 8'hA5);

        // read-during-write returns old data
        AddressR = 8'h10;
        wr(1'b0, 10'h010, 8'h44);
        check("rdw_old", R, 8'h33);
        tick();
        check("rdw_new", R, 8'h44);

        // out-of-range R write must not alias onto R[0x05] nor land in S
        wr(1'b0, 10'h105, 8'h7F);
        AddressR = 8'h05; AddressS1 = 10'h105;
        tick();
        check("oor_R05", R, 8'h00);
        check("oor_S105", S1, 8'h00);

        // mid-run reset: async clear, blocked write, contents retained
        AddressR = 8'h20; AddressS1 = 10'd100; AddressS2 = 10'd200;
        tick();
        check("pre_R", R, 8'hAA);
        check("pre_S1", S1, 8'hAA);
        check("pre_S2", S2, 8'hBB);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_R", R, 8'h00);
        check("async_S1", S1, 8'h00);
        check("async_S2", S2, 8'h00);
        we = 1'b1; wsel = 1'b0; waddr = 10'h020; wdata = 8'h55;
        tick();
        check("inrst_R", R, 8'h00);
        we = 1'b1; wsel = 1'b1; waddr = 10'd100; wdata = 8'h66;
        tick();
        check("inrst_S1", S1, 8'h00);
        we = 1'b0;
        reset_n = 1'b1;
        tick();
        check("post_R", R, 8'hAA);
        check("post_S1", S1, 8'hAA);
        check("post_S2", S2, 8'hBB);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
